ext_io_test_seq: RTL and testbench



---
 rtl/ext_io_pkg.sv | 20 ++
 rtl/ext_io_dwell_timer.sv | 39 +++
 rtl/ext_io_test_seq.sv | 190 +++++++++++++++++++
 tb/tb_ext_io_test_seq.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/ext_io_pkg.sv
// Shared definitions for the extension IO bank self-test sequencer.
//   phase_e   : 3-bit phase code, also presented on the sequencer's phase output
//   IO_W_DEF  : default number of extension IO pins (multiple of 4)
//   PIN_IDX_W : width of the pin_idx output
package ext_io_pkg;

   typedef enum logic [2:0] {
      PH_IDLE   = 3'd0,
      PH_ALL_LO = 3'd1,
      PH_ALL_HI = 3'd2,
      PH_WALK1  = 3'd3,
      PH_WALK0  = 3'd4,
      PH_CNT    = 3'd5,
      PH_DONE   = 3'd6
   } phase_e;

   localparam int IO_W_DEF  = 36;
   localparam int PIN_IDX_W = 6;

endpackage

// File: rtl/ext_io_dwell_timer.sv
// Loadable down-counter that times each step of the self-test schedule.
//   clk40M   : system clock, rising edge
//   rst      : synchronous active-high reset (count -> 0)
//   load     : load load_val on this edge (takes priority over counting)
//   load_val : value to load, normally dwell-1
//   expire   : high while the count reads 0; the current step ends on this cycle
module ext_io_dwell_timer #(
   parameter int DWELL_W = 16
) (
   input  logic               clk40M,
   input  logic               rst,
   input  logic               load,
   input  logic [DWELL_W-1:0] load_val,
   output logic               expire
);

   logic [DWELL_W-1:0] count_q;
   logic [DWELL_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (count_q != '0) begin
         count_d = count_q - DWELL_W'(1);
      end
   end

   always_ff @(posedge clk40M) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expire = (count_q == '0);

endmodule

// File: rtl/ext_io_test_seq.sv
// Self-test sequencer for the extension IO bank.
// On an accepted start it drives the bank through ALL_LO, ALL_HI, WALK1,
// WALK0 and a divided-counter phase, then pulses done for one cycle.
//   clk40M  : 40 MHz clock, all logic on its rising edge
//   rst     : synchronous active-high reset
//   start   : one-cycle request, accepted only in IDLE with abort low
//   abort   : level-sampled; returns to IDLE on the next edge from any busy/DONE state
//   loop_en : restart from ALL_LO after DONE
//   dwell   : cycles per step, latched on start / loop restart, 0 behaves as 1
//   ext_io  : registered pin drive
//   busy    : high from ALL_LO through CNT
//   done    : one-cycle pulse in the DONE phase
//   phase   : current phase code (also the FSM state for observation)
//   pin_idx : active pin during WALK1/WALK0, 0 otherwise
// Next-state and next-output values are computed together in one always_comb,
// so every output is registered and moves on the same edge as the phase.
module ext_io_test_seq
   import ext_io_pkg::*;
#(
   parameter int IO_W    = IO_W_DEF,
   parameter int CNT_W   = 16,
   parameter int DWELL_W = 16
) (
   input  logic                 clk40M,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   input  logic                 loop_en,
   input  logic [DWELL_W-1:0]   dwell,
   output logic [IO_W-1:0]      ext_io,
   output logic                 busy,
   output logic                 done,
   output logic [2:0]           phase,
   output logic [PIN_IDX_W-1:0] pin_idx
);

   localparam logic [PIN_IDX_W-1:0] LAST_PIN = PIN_IDX_W'(IO_W - 1);
   localparam logic [IO_W-1:0]      ONE_HOT0 = IO_W'(1);

   phase_e                 phase_q,   phase_d;
   logic [DWELL_W-1:0]     dwell_q,   dwell_d;
   logic [PIN_IDX_W-1:0]   pin_idx_q, pin_idx_d;
   logic [CNT_W-1:0]       cnt_q,     cnt_d;
   logic [IO_W-1:0]        ext_io_q,  ext_io_d;
   logic                   busy_q,    busy_d;
   logic                   done_q,    done_d;

   logic                   tmr_load;
   logic [DWELL_W-1:0]     tmr_load_val;
   logic                   tmr_expire;
   logic [DWELL_W-1:0]     dwell_eff;

   ext_io_dwell_timer #(.DWELL_W(DWELL_W)) u_dwell_timer (
      .clk40M   (clk40M),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_load_val),
      .expire   (tmr_expire)
   );

   always_comb begin
      dwell_eff    = (dwell == '0) ? DWELL_W'(1) : dwell;
      phase_d      = phase_q;
      dwell_d      = dwell_q;
      pin_idx_d    = pin_idx_q;
      cnt_d        = '0;
      tmr_load     = 1'b0;
      tmr_load_val = dwell_q - DWELL_W'(1);

      unique case (phase_q)
         PH_IDLE: begin
            if (start && !abort) begin
               phase_d      = PH_ALL_LO;
               dwell_d      = dwell_eff;
               tmr_load     = 1'b1;
               // dwell_q is not yet latched, so load from the live input
               tmr_load_val = dwell_eff - DWELL_W'(1);
            end
         end
         PH_ALL_LO: begin
            if (tmr_expire) begin
               phase_d  = PH_ALL_HI;
               tmr_load = 1'b1;
            end
         end
         PH_ALL_HI: begin
            if (tmr_expire) begin
               phase_d   = PH_WALK1;
               pin_idx_d = '0;
               tmr_load  = 1'b1;
            end
         end
         PH_WALK1: begin
            if (tmr_expire) begin
               tmr_load = 1'b1;
               if (pin_idx_q == LAST_PIN) begin
                  phase_d   = PH_WALK0;
                  pin_idx_d = '0;
               end else begin
                  pin_idx_d = pin_idx_q + PIN_IDX_W'(1);
               end
            end
         end
         PH_WALK0: begin
            if (tmr_expire) begin
               if (pin_idx_q == LAST_PIN) begin
                  // cnt_d defaults to 0, so the counter phase starts at 0
                  phase_d   = PH_CNT;
                  pin_idx_d = '0;
               end else begin
                  tmr_load  = 1'b1;
                  pin_idx_d = pin_idx_q + PIN_IDX_W'(1);
               end
            end
         end
         PH_CNT: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == '1) begin
               phase_d = PH_DONE;
            end
         end
         PH_DONE: begin
            if (loop_en) begin
               phase_d      = PH_ALL_LO;
               dwell_d      = dwell_eff;
               tmr_load     = 1'b1;
               tmr_load_val = dwell_eff - DWELL_W'(1);
            end else begin
               phase_d = PH_IDLE;
            end
         end
         default: begin
            phase_d = PH_IDLE;
         end
      endcase

      // Abort overrides every transition above, including a loop restart in DONE.
      if (abort && (phase_q != PH_IDLE)) begin
         phase_d   = PH_IDLE;
         pin_idx_d = '0;
         cnt_d     = '0;
         tmr_load  = 1'b0;
      end

      busy_d = (phase_d != PH_IDLE) && (phase_d != PH_DONE);
      done_d = (phase_d == PH_DONE);

      ext_io_d = '0;
      unique case (phase_d)
         PH_ALL_HI: ext_io_d = '1;
         PH_WALK1:  ext_io_d = ONE_HOT0 << pin_idx_d;
         PH_WALK0:  ext_io_d = ~(ONE_HOT0 << pin_idx_d);
         PH_CNT: begin
            // Every 4-pin group carries the same top four counter bits,
            // giving each group the same four divided frequencies.
            for (int k = 0; k < IO_W / 4; k++) begin
               ext_io_d[4*k +: 4] = cnt_d[CNT_W-1 -: 4];
            end
         end
         default:   ext_io_d = '0;
      endcase
   end

   always_ff @(posedge clk40M) begin
      if (rst) begin
         phase_q   <= PH_IDLE;
         dwell_q   <= '0;
         pin_idx_q <= '0;
         cnt_q     <= '0;
         ext_io_q  <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         phase_q   <= phase_d;
         dwell_q   <= dwell_d;
         pin_idx_q <= pin_idx_d;
         cnt_q     <= cnt_d;
         ext_io_q  <= ext_io_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign ext_io  = ext_io_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign phase   = phase_q;
   assign pin_idx = pin_idx_q;

endmodule

// File: tb/tb_ext_io_test_seq.sv
// Directed bench for ext_io_test_seq with IO_W=36, CNT_W=4.
// Inputs change and outputs are sampled on the falling edge.
module tb_ext_io_test_seq;

   localparam int IO_W    = 36;
   localparam int CNT_W   = 4;
   localparam int DWELL_W = 16;

   logic               clk40M = 1'b0;
   logic               rst;
   logic               start;
   logic               abort;
   logic               loop_en;
   logic [DWELL_W-1:0] dwell;
   logic [IO_W-1:0]    ext_io;
   logic               busy;
   logic               done;
   logic [2:0]         phase;
   logic [5:0]         pin_idx;

   int n_checks = 0;
   int n_fail   = 0;

   ext_io_test_seq #(.IO_W(IO_W), .CNT_W(CNT_W), .DWELL_W(DWELL_W)) dut (
      .clk40M  (clk40M),
      .rst     (rst),
      .start   (start),
      .abort   (abort),
      .loop_en (loop_en),
      .dwell   (dwell),
      .ext_io  (ext_io),
      .busy    (busy),
      .done    (done),
      .phase   (phase),
      .pin_idx (pin_idx)
   );

   always #5 clk40M = ~clk40M;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected pattern at busy cycle c of a pass with dwell d (IO_W=36, CNT_W=4).
   task automatic exp_at(input int c, input int d, output logic [2:0] ph,
                         output logic [IO_W-1:0] io, output logic [5:0] pi);
      logic [IO_W-1:0] one;
      logic [3:0]      v;
      one = 36'd1;
      pi  = 6'd0;
      if (c < d) begin
         ph = 3'd1; io = '0;
      end else if (c < 2*d) begin
         ph = 3'd2; io = '1;
      end else if (c < 38*d) begin
         ph = 3'd3; pi = 6'((c - 2*d) / d); io = one << pi;
      end else if (c < 74*d) begin
         ph = 3'd4; pi = 6'((c - 38*d) / d); io = ~(one << pi);
      end else begin
         ph = 3'd5; v = 4'(c - 74*d); io = {9{v}};
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_phase"}, 64'(phase), 64'd0);
      chk({tag, "_io"}, 64'(ext_io), 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_done"}, 64'(done), 64'd0);
      chk({tag, "_pin"}, 64'(pin_idx), 64'd0);
   endtask

   // Entry: at the falling edge showing busy cycle 0. Exit: at the DONE cycle.
   // poke_c pulses start, dw_c changes dwell to dw_val, lp_c clears loop_en.
   task automatic check_pass(input int d, input int poke_c, input int dw_c,
                             input logic [DWELL_W-1:0] dw_val, input int lp_c);
      int              len;
      logic [2:0]      eph;
      logic [IO_W-1:0] eio;
      logic [5:0]      epi;
      len = 2*d + 72*d + 16;
      for (int c = 0; c < len; c++) begin
         start = 1'b0;
         exp_at(c, d, eph, eio, epi);
         chk($sformatf("d%0d_c%0d_phase", d, c), 64'(phase), 64'(eph));
         chk($sformatf("d%0d_c%0d_io", d, c), 64'(ext_io), 64'(eio));
         chk($sformatf("d%0d_c%0d_pin", d, c), 64'(pin_idx), 64'(epi));
         chk($sformatf("d%0d_c%0d_busy", d, c), 64'(busy), 64'd1);
         chk($sformatf("d%0d_c%0d_done", d, c), 64'(done), 64'd0);
         if (c == poke_c) start = 1'b1;
         if (c == dw_c) dwell = dw_val;
         if (c == lp_c) loop_en = 1'b0;
         @(negedge clk40M);
      end
      start = 1'b0;
      chk($sformatf("d%0d_done_phase", d), 64'(phase), 64'd6);
      chk($sformatf("d%0d_done_pulse", d), 64'(done), 64'd1);
      chk($sformatf("d%0d_done_busy", d), 64'(busy), 64'd0);
      chk($sformatf("d%0d_done_io", d), 64'(ext_io), 64'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; loop_en = 1'b0; dwell = 16'd2;

      // Reset, then idle with start low
      repeat (3) @(negedge clk40M);
      chk_idle("reset");
      rst = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk40M);
         chk("idle_hold", {busy, done, phase, ext_io}, 64'd0);
      end

      // Full pass, dwell=2: 164 busy cycles, then DONE, then IDLE
      dwell = 16'd2; start = 1'b1;
      @(negedge clk40M);
      check_pass(2, -1, -1, '0, -1);
      @(negedge clk40M);
      chk_idle("after_d2");

      // dwell=0 behaves as dwell=1: 90 busy cycles
      dwell = 16'd0; start = 1'b1;
      @(negedge clk40M);
      check_pass(1, -1, -1, '0, -1);
      @(negedge clk40M);
      chk_idle("after_d0");

      // Abort at WALK1 pin 10 (dwell=2 -> busy cycle 24)
      dwell = 16'd2; start = 1'b1;
      @(negedge clk40M);
      start = 1'b0;
      repeat (24) @(negedge clk40M);
      chk("abort_pre_phase", 64'(phase), 64'd3);
      chk("abort_pre_pin", 64'(pin_idx), 64'd10);
      chk("abort_pre_io", 64'(ext_io), 64'(36'd1 << 10));
      abort = 1'b1;
      @(negedge clk40M);
      abort = 1'b0;
      chk_idle("abort_post");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk40M);
         chk("abort_no_done", {busy, done, phase}, 64'd0);
      end
      // Restart after abort begins again from ALL_LO
      start = 1'b1;
      @(negedge clk40M);
      check_pass(2, -1, -1, '0, -1);
      @(negedge clk40M);
      chk_idle("after_restart");

      // Start together with abort in IDLE is refused
      start = 1'b1; abort = 1'b1;
      @(negedge clk40M);
      start = 1'b0; abort = 1'b0;
      chk_idle("start_abort");
      @(negedge clk40M);
      chk_idle("start_abort_2");

      // Start during ALL_HI (dwell=1 -> busy cycle 1) changes nothing
      dwell = 16'd1; start = 1'b1;
      @(negedge clk40M);
      check_pass(1, 1, -1, '0, -1);
      @(negedge clk40M);
      chk_idle("after_poke");

      // Loop mode: two dwell=1 passes 91 cycles apart; dwell->3 in pass 2
      // only applies to pass 3; loop_en cleared during pass 3
      loop_en = 1'b1; dwell = 16'd1; start = 1'b1;
      @(negedge clk40M);
      check_pass(1, -1, -1, '0, -1);
      @(negedge clk40M);
      check_pass(1, -1, 40, 16'd3, -1);
      @(negedge clk40M);
      check_pass(3, -1, -1, '0, 10);
      @(negedge clk40M);
      chk_idle("after_loop");

      // Abort in the DONE cycle wins over loop_en
      loop_en = 1'b1; dwell = 16'd1; start = 1'b1;
      @(negedge clk40M);
      check_pass(1, -1, -1, '0, -1);
      abort = 1'b1;
      @(negedge clk40M);
      abort = 1'b0; loop_en = 1'b0;
      chk_idle("abort_in_done");

      // Reset in the middle of a sequence
      dwell = 16'd2; start = 1'b1;
      @(negedge clk40M);
      start = 1'b0;
      repeat (10) @(negedge clk40M);
      chk("mid_rst_pre_busy", 64'(busy), 64'd1);
      rst = 1'b1;
      @(negedge clk40M);
      rst = 1'b0;
      chk_idle("mid_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
